// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - AXI4 read-master LED pattern sequencer
//
// Fetches 512-bit beats (16 x 32-bit entries) from the pattern table in AXI RAM
// and shows each entry on led for its hold time.
// Entry format: [7:0] LED value, [31:8] hold in ticks (0 is treated as 1).
// One tick is TICK_DIV clk cycles.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start, stop                      one-cycle control pulses
//   cfg_base_addr, cfg_num_entries   table base (64-byte aligned) and entry count
//   busy, done, err, led             status and LED drive
//   m_axi_ar*, m_axi_r*              single-beat AXI4 read master (AR and R channels)
//
// Optional build macro LED_SEQ_LOOP_EN: the table replays until stop, and done
// pulses at the end of each pass.

module led_seq_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4,
  parameter int TICK_DIV   = 250000,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]      cfg_num_entries,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            led,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = CNT_W - 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_R     = 3'd2,
    S_PLAY  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [7:0]              led_q, led_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [CNT_W-1:0]        num_q, num_d;
  logic [CNT_W-1:0]        remain_q, remain_d;
  logic [BW-1:0]           beat_idx_q, beat_idx_d;
  logic [3:0]              k_q, k_d;
  logic [DATA_WIDTH-1:0]   beat_q, beat_d;
  logic [23:0]             hold_q, hold_d;
  logic [PW-1:0]           presc_q, presc_d;

  logic [31:0]             next_word;
  logic                    tick;
  logic                    expire;
  logic                    unused_inputs;

  function automatic logic [31:0] entry_at(input logic [DATA_WIDTH-1:0] b, input logic [3:0] k);
    return b[{k, 5'b0} +: 32];
  endfunction

  function automatic logic [23:0] hold_of(input logic [31:0] w);
    return (w[31:8] == 24'd0) ? 24'd1 : w[31:8];
  endfunction

  // Address arithmetic wraps at ADDR_WIDTH bits.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] b,
                                                      input logic [BW-1:0] idx);
    return b + (ADDR_WIDTH'(idx) << 6);
  endfunction

  assign next_word = entry_at(beat_q, k_q + 4'd1);
  // An entry expires on the last cycle of its last tick; prescaler restarts at each load.
  assign tick      = (presc_q == '0);
  assign expire    = tick && (hold_q == 24'd1);

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    led_d      = led_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    araddr_d   = araddr_q;
    base_d     = base_q;
    num_d      = num_q;
    remain_d   = remain_q;
    beat_idx_d = beat_idx_q;
    k_d        = k_q;
    beat_d     = beat_q;
    hold_d     = hold_q;
    presc_d    = presc_q;

    case (state_q)
      S_IDLE: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          err_d    = 1'b0;
          base_d   = {cfg_base_addr[ADDR_WIDTH-1:6], 6'b0};
          num_d    = cfg_num_entries;
          remain_d = cfg_num_entries;
          if (cfg_num_entries == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d     = 1'b1;
            beat_idx_d = '0;
            araddr_d   = {cfg_base_addr[ADDR_WIDTH-1:6], 6'b0};
            arvalid_d  = 1'b1;
            state_d    = S_AR;
          end
        end
      end

      S_AR: begin
        if (m_axi_arready) begin
          // Request is out; a stop now must still swallow the returning beat.
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = stop ? S_DRAIN : S_R;
        end else if (stop) begin
          arvalid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_R: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          if (m_axi_rresp != 2'b00) begin
            err_d   = 1'b1;
            led_d   = 8'h00;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (stop) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            beat_d  = m_axi_rdata;
            k_d     = 4'd0;
            led_d   = m_axi_rdata[7:0];
            hold_d  = hold_of(m_axi_rdata[31:0]);
            presc_d = PW'(TICK_DIV - 1);
            state_d = S_PLAY;
          end
        end else if (stop) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_PLAY: begin
        if (expire) begin
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            // Completion wins over a coincident stop.
            done_d = 1'b1;
`ifdef LED_SEQ_LOOP_EN
            if (stop) begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              remain_d   = num_q;
              beat_idx_d = '0;
              araddr_d   = base_q;
              arvalid_d  = 1'b1;
              state_d    = S_AR;
            end
`else
            busy_d  = 1'b0;
            state_d = S_IDLE;
`endif
          end else if (stop) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (k_q == 4'd15) begin
            beat_idx_d = beat_idx_q + BW'(1);
            araddr_d   = beat_addr(base_q, beat_idx_q + BW'(1));
            arvalid_d  = 1'b1;
            state_d    = S_AR;
          end else begin
            k_d     = k_q + 4'd1;
            led_d   = next_word[7:0];
            hold_d  = hold_of(next_word);
            presc_d = PW'(TICK_DIV - 1);
          end
        end else if (stop) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (tick) begin
          hold_d  = hold_q - 24'd1;
          presc_d = PW'(TICK_DIV - 1);
        end else begin
          presc_d = presc_q - PW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      led_q      <= 8'h00;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
      base_q     <= '0;
      num_q      <= '0;
      remain_q   <= '0;
      beat_idx_q <= '0;
      k_q        <= 4'd0;
      beat_q     <= '0;
      hold_q     <= 24'd0;
      presc_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      led_q      <= led_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      araddr_q   <= araddr_d;
      base_q     <= base_d;
      num_q      <= num_d;
      remain_q   <= remain_d;
      beat_idx_q <= beat_idx_d;
      k_q        <= k_d;
      beat_q     <= beat_d;
      hold_q     <= hold_d;
      presc_q    <= presc_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign led           = led_q;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'd6;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

  // Single-beat reads: rid and rlast carry no information; base low bits are ignored.
  assign unused_inputs = ^{m_axi_rid, m_axi_rlast, cfg_base_addr[5:0]};

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- AXI4 read-master sequencer that plays an LED pattern table stored in the XDMA-accessible 512-bit AXI RAM onto LED[7:0].
- Host writes the table through XDMA, then pulses start.
- Block fetches one 512-bit beat at a time (16 entries), shows each entry for its programmed hold time, then fetches the next beat.
- Sits on axi_aclk beside axi_ram as a second read requester (via the team's AXI interconnect).

Parameters:
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 512, AXI data width; fixed at 512 (16 x 32-bit entries per beat)
ID_WIDTH, 4, AXI ID width
TICK_DIV, 250000, clk cycles per hold tick (1 ms at 250 MHz)
CNT_W, 16, width of entry count

Ports:
clk  in  1  axi_aclk domain clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begin playback
stop  in  1  one-cycle pulse; abort playback
cfg_base_addr  in  ADDR_WIDTH  table base address; bits [5:0] ignored (treated as 0)
cfg_num_entries  in  CNT_W  number of 32-bit entries to play
busy  out  1  high from accepted start until IDLE
done  out  1  one-cycle pulse at normal completion
err  out  1  sticky; set on non-OKAY rresp; cleared by next accepted start
led  out  8  LED drive
m_axi_arid  out  ID_WIDTH  constant 0
m_axi_araddr  out  ADDR_WIDTH  beat address
m_axi_arlen  out  8  constant 0
m_axi_arsize  out  3  constant 3'd6
m_axi_arburst  out  2  constant 2'b01
m_axi_arlock  out  1  constant 0
m_axi_arcache  out  4  constant 4'b0011
m_axi_arprot  out  3  constant 0
m_axi_arvalid  out  1  read request valid
m_axi_arready  in  1  read request ready
m_axi_rid  in  ID_WIDTH  ignored
m_axi_rdata  in  DATA_WIDTH  beat data
m_axi_rresp  in  2  response
m_axi_rlast  in  1  ignored (single beat)
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Clock/reset: one clock clk; rst synchronous, active-high.
- Reset values: busy=0, done=0, err=0, led=8'h00, arvalid=0, rready=0, state=IDLE.
- Entry format: bits [7:0] LED value, bits [31:8] hold H in ticks. H=0 is treated as 1. Entry k of a beat is rdata[32k+31:32k].
- States:
  - IDLE: start accepted and entries latched. If latched count is 0, pulse done next cycle, no AXI traffic, stay IDLE, busy stays 0. Otherwise set busy, beat_idx=0, go AR.
  - AR: arvalid=1, araddr = {base[AW-1:6],6'b0} + beat_idx*64. araddr and arvalid are stable until arready. On handshake go R.
  - R: rready=1. On rvalid, capture the beat.
    - rresp != 2'b00: set err, led=8'h00, go IDLE, no done pulse.
    - Otherwise go PLAY with k=0.
  - PLAY: led loaded with entry k on the cycle after capture or after the previous entry's expiry. Entry shown exactly H*TICK_DIV cycles (prescaler restarts at each load). On expiry:
    - Remaining count reaches 0: done pulse, busy=0, IDLE.
    - k=15: beat_idx++, go AR.
    - Otherwise k++.
  - DRAIN: see stop handling below.
- Timing: start→arvalid is 1 cycle. R handshake→led update is 1 cycle.
- led holds the last value during AR/R fetch gaps; fetch latency extends the displayed time of entry 15.
- Counters: remaining-entries counter is CNT_W bits. beat_idx is CNT_W-4 bits. Address arithmetic is ADDR_WIDTH-bit and wraps modulo 2^ADDR_WIDTH.
- start while busy: ignored.
- stop:
  - In AR before handshake: arvalid may drop immediately; go IDLE.
  - In R: go DRAIN (rready=1, discard one beat, then IDLE).
  - In PLAY: IDLE next cycle.
  - led keeps its last value; no done pulse.
- start and stop in the same cycle in IDLE: stop wins; start ignored.
- A last-entry expiry coinciding with stop: done is pulsed (completion wins).
- rst mid-transaction: immediate return to reset values. The interconnect/RAM share the same reset, so no stale R beat is expected.

Optional Feature:
- Macro LED_SEQ_LOOP_EN.
- Defined: on last-entry expiry, pulse done, reload count, beat_idx=0, go AR. Playback repeats until stop, and busy stays 1.
- Undefined: single pass as above.

Test Plan:
- TICK_DIV=4, base=0x1000, num=3, entries {H=1 0x01, H=2 0x02, H=0 0x03}, RAM latency 2 → one AR at 0x1000; led shows 0x01 for 4, 0x02 for 8, 0x03 for 4 cycles; then done pulse, busy=0, led stays 0x03.
- num=20 → AR at base then base+0x40; entries 16–19 come from beat 2; exactly 2 ARs; done once.
- arready held low 10 cycles → araddr/arvalid stable throughout; exactly one request issued.
- rresp=2'b10 on first beat → err=1, led=0, busy=0, no done. Next start clears err.
- stop while in R (rvalid delayed 5 cycles) → beat consumed with rready, IDLE, no new AR, no done. start with num=0 → done pulse, zero AR.
- LED_SEQ_LOOP_EN defined, num=2 → done pulses each pass, AR to base repeats, busy stays 1 until stop.
